router_link_pipelined: RTL and testbench
========================================

Name: router_link_pipelined

Overview:
- Parametrised successor to the direct router-to-router link used in mesh assembly.
- Inserts STAGES retiming registers on long inter-router wires, forward for flits and backward for on/off and allocatable.
- A per-VC landing buffer sits at the downstream end and absorbs in-flight flits, so on/off flow control stays lossless at any STAGES.
- Instantiated between one router's *_down interface and the neighbour's *_up interface, or on the local port toward a node.

Parameters:
STAGES, 2, forward and backward pipeline depth in cycles; legal range 1..8.
SKID_EXTRA, 2, buffer slots beyond round-trip need; legal range 1..8.
VC_NUM, noc_pkg VC_NUM, number of virtual channels; not overridable locally.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
data_i  in  $bits(flit_t)  upstream flit; field vc_id selects the VC
is_valid_i  in  1  upstream flit valid
is_on_off_o  out  VC_NUM  per-VC on/off to upstream (1 = may send)
is_allocatable_o  out  VC_NUM  per-VC allocatable to upstream, delayed copy of is_allocatable_i
data_o  out  $bits(flit_t)  downstream flit
is_valid_o  out  1  downstream flit valid
is_on_off_i  in  VC_NUM  per-VC on/off from downstream
is_allocatable_i  in  VC_NUM  per-VC allocatable from downstream
overflow_o  out  VC_NUM  sticky per-VC landing-buffer overflow flag
flit_count_o  out  VC_NUM*16  per-VC delivered-flit counters (see Optional Feature)

Behaviour:
- Reset is asynchronous and active-high on rst. Clock is clk.
- Reset values:
  - All forward-stage valids = 0. Stage data regs are don't-care.
  - Backward on_off and allocatable stages = 0.
  - is_valid_o = 0, data_o = 0.
  - Landing FIFOs empty, overflow_o = 0, flit_count_o = 0, round-robin pointer = 0.
- Local constants: RTT = 2*STAGES+1, DEPTH = RTT+SKID_EXTRA per VC.
- Forward path:
  - {is_valid_i, data_i} shifts through STAGES registers.
  - When the tail stage is valid, the flit is written into FIFO[vc_id] in that cycle; it becomes readable the next cycle.
- Write into a full FIFO:
  - The flit is dropped and overflow_o[vc] sets.
  - overflow_o[vc] stays set until rst.
  - Other VCs are unaffected.
- Output arbitration, evaluated each cycle:
  - Eligible[v] = FIFO[v] non-empty AND is_on_off_i[v].
  - Round-robin pick starts at the pointer.
  - The winner is popped, and registered into data_o / is_valid_o = 1 the next cycle.
  - The pointer moves to winner+1 mod VC_NUM.
  - No eligible VC: is_valid_o = 0, data_o holds its last value, pointer unchanged.
  - At most one flit out per cycle.
- Minimum latency, is_valid_i to is_valid_o: STAGES+2 cycles.
- Simultaneous write and pop on the same VC is legal: occupancy is unchanged.
- Backward on/off:
  - raw[v] = (DEPTH - count[v]) > RTT, using the registered count.
  - raw passes through STAGES registers to is_on_off_o.
  - Upstream sending every cycle while is_on_off_o = 1 must never overflow; this is a verification invariant.
- is_allocatable_o = is_allocatable_i delayed STAGES cycles.
- Counters:
  - count[v] width = $clog2(DEPTH+1).
  - FIFO pointers wrap modulo DEPTH; DEPTH need not be a power of two.
- Reset mid-operation: all in-flight and buffered flits are discarded, no output glitch beyond the async clear, and state is as listed above.
- vc_id >= VC_NUM (only possible when VC_NUM is not a power of two): flit dropped, no flag. Covered by an assertion only.

Optional Feature:
Macro LINK_STATS_EN.
- Defined:
  - flit_count_o[v*16 +: 16] increments on each flit delivered on VC v (is_valid_o rising with that VC).
  - Wraps 0xFFFF -> 0.
  - Cleared by rst.
- Undefined: flit_count_o is tied to 0 and no counter flops are built. The port list is identical either way.

Test Plan:
1. STAGES=2, VC_NUM=2, downstream on: one flit vc0 at cycle 10 -> is_valid_o=1 at cycle 14 with identical data; is_on_off_o stays 11.
2. Downstream is_on_off_i=00, upstream streams vc0 while is_on_off_o[0]=1 -> is_on_off_o[0] falls once count[0]>=2 (DEPTH=7, RTT=5). Final count[0]=7, overflow_o=00, zero flits lost after is_on_off_i=11.
3. Both VCs full, is_on_off_i=11 -> output alternates vc0,vc1,vc0,... one flit per cycle, 14 flits in 14 consecutive cycles.
4. Force 8 writes to vc1 with on/off ignored and downstream off -> overflow_o=10 from the 8th write; the first 7 flits are delivered intact after release.
5. Assert rst for 1 cycle mid-stream with 3 flits buffered -> is_valid_o=0 immediately and no buffered flit ever emerges. is_on_off_o returns to 11 STAGES+1 cycles after rst deasserts.
6. LINK_STATS_EN defined, 0x10002 flits on vc0 -> flit_count_o[15:0]=0x0002, flit_count_o[31:16]=0. Undefined -> flit_count_o stays 0.

Source files
------------

// File: rtl/router_link_pipelined.sv
// router_link_pipelined: retimed router-to-router link with per-VC landing buffers.
// Flits travel forward through STAGES registers and land in a per-VC FIFO sized
// for the full on/off round trip. A round-robin arbiter drains the FIFOs toward
// the downstream router. On/off and allocatable travel backward through STAGES
// registers.
// Optional feature: define LINK_STATS_EN to build per-VC delivered-flit counters;
// otherwise flit_count_o is tied to zero.

package noc_pkg;
    localparam int VC_NUM    = 2;
    localparam int VC_SIZE   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int PAYLOAD_W = 32;

    // vc_id is the most significant field; the link extracts it by position.
    typedef struct packed {
        logic [VC_SIZE-1:0]   vc_id;
        logic [PAYLOAD_W-1:0] payload;
    } flit_t;
endpackage

module router_link_pipelined
    import noc_pkg::*;
#(
    parameter int STAGES     = 2,
    parameter int SKID_EXTRA = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [$bits(flit_t)-1:0]     data_i,
    input  logic                         is_valid_i,
    output logic [VC_NUM-1:0]            is_on_off_o,
    output logic [VC_NUM-1:0]            is_allocatable_o,
    output logic [$bits(flit_t)-1:0]     data_o,
    output logic                         is_valid_o,
    input  logic [VC_NUM-1:0]            is_on_off_i,
    input  logic [VC_NUM-1:0]            is_allocatable_i,
    output logic [VC_NUM-1:0]            overflow_o,
    output logic [VC_NUM*16-1:0]         flit_count_o
);

    localparam int DATA_W = $bits(flit_t);
    localparam int RTT    = 2 * STAGES + 1;
    localparam int DEPTH  = RTT + SKID_EXTRA;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int PTR_W  = $clog2(DEPTH);

    // Advance a FIFO pointer; DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Next round-robin start position after a grant.
    function automatic logic [VC_SIZE-1:0] f_vc_inc(input logic [VC_SIZE-1:0] v);
        return (v == VC_SIZE'(VC_NUM - 1)) ? '0 : v + 1'b1;
    endfunction

    // Forward retiming stages (index STAGES-1 is the tail feeding the FIFOs).
    logic                r_fwd_vld_p  [STAGES];
    logic [DATA_W-1:0]   r_fwd_data_p [STAGES];

    // Backward retiming stages (index STAGES-1 drives the upstream ports).
    logic [VC_NUM-1:0]   r_onoff_p    [STAGES];
    logic [VC_NUM-1:0]   r_alloc_p    [STAGES];

    // Landing buffers.
    logic [DATA_W-1:0]   r_mem        [VC_NUM][DEPTH];
    logic [PTR_W-1:0]    r_wptr       [VC_NUM];
    logic [PTR_W-1:0]    r_rptr       [VC_NUM];
    logic [CNT_W-1:0]    r_cnt        [VC_NUM];
    logic [VC_NUM-1:0]   r_overflow;

    // Arbiter and output register.
    logic [VC_SIZE-1:0]  r_rr_ptr;
    logic                r_valid_o;
    logic [DATA_W-1:0]   r_data_o;

    logic                w_tail_vld;
    logic [DATA_W-1:0]   w_tail_data;
    logic [VC_SIZE-1:0]  w_tail_vc;
    logic [VC_NUM-1:0]   w_wr;
    logic [VC_NUM-1:0]   w_full;
    logic [VC_NUM-1:0]   w_push;
    logic [VC_NUM-1:0]   w_drop;
    logic [VC_NUM-1:0]   w_elig;
    logic [VC_NUM-1:0]   w_pop;
    logic [VC_NUM-1:0]   w_raw_on;
    logic                w_grant_vld;
    logic [VC_SIZE-1:0]  w_grant_vc;
    logic [DATA_W-1:0]   w_rd_data;

    // ---- forward stages p0..p(STAGES-1) ----
    // Valid chain is control and is cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) r_fwd_vld_p[i] <= 1'b0;
        end else begin
            r_fwd_vld_p[0] <= is_valid_i;
            for (int i = 1; i < STAGES; i++) r_fwd_vld_p[i] <= r_fwd_vld_p[i-1];
        end
    end

    // Data chain carries payload only; its content is qualified by the valid chain.
    always_ff @(posedge clk) begin
        r_fwd_data_p[0] <= data_i;
        for (int i = 1; i < STAGES; i++) r_fwd_data_p[i] <= r_fwd_data_p[i-1];
    end

    assign w_tail_vld  = r_fwd_vld_p[STAGES-1];
    assign w_tail_data = r_fwd_data_p[STAGES-1];
    assign w_tail_vc   = w_tail_data[DATA_W-1 -: VC_SIZE];

    // ---- landing buffer write side and on/off source ----
    // Per-VC write/full/eligibility decode plus the raw on/off from registered occupancy.
    always_comb begin
        w_wr     = '0;
        w_full   = '0;
        w_push   = '0;
        w_drop   = '0;
        w_elig   = '0;
        w_raw_on = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            w_wr[v]     = w_tail_vld && (w_tail_vc == VC_SIZE'(v));
            w_full[v]   = (r_cnt[v] == CNT_W'(DEPTH));
            w_push[v]   = w_wr[v] && !w_full[v];
            w_drop[v]   = w_wr[v] && w_full[v];
            w_elig[v]   = (r_cnt[v] != '0) && is_on_off_i[v];
            w_raw_on[v] = (DEPTH - int'(r_cnt[v])) > RTT;
        end
    end

    // Round-robin pick starting at r_rr_ptr; at most one grant per cycle.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_vc  = '0;
        for (int i = 0; i < VC_NUM; i++) begin
            logic [VC_SIZE-1:0] idx;
            idx = VC_SIZE'((int'(r_rr_ptr) + i) % VC_NUM);
            if (!w_grant_vld && w_elig[idx]) begin
                w_grant_vld = 1'b1;
                w_grant_vc  = idx;
            end
        end
    end

    // Pop strobe per VC derived from the single grant.
    always_comb begin
        w_pop = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            w_pop[v] = w_grant_vld && (w_grant_vc == VC_SIZE'(v));
        end
    end

    assign w_rd_data = r_mem[w_grant_vc][r_rptr[w_grant_vc]];

    // Buffer storage: write the tail flit into its VC when there is room.
    always_ff @(posedge clk) begin
        for (int v = 0; v < VC_NUM; v++) begin
            if (w_push[v]) r_mem[v][r_wptr[v]] <= w_tail_data;
        end
    end

    // Buffer pointers, occupancy and sticky overflow per VC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < VC_NUM; v++) begin
                r_wptr[v] <= '0;
                r_rptr[v] <= '0;
                r_cnt[v]  <= '0;
            end
            r_overflow <= '0;
        end else begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (w_push[v]) r_wptr[v] <= f_ptr_inc(r_wptr[v]);
                if (w_pop[v])  r_rptr[v] <= f_ptr_inc(r_rptr[v]);
                case ({w_push[v], w_pop[v]})
                    2'b10:   r_cnt[v] <= r_cnt[v] + 1'b1;
                    2'b01:   r_cnt[v] <= r_cnt[v] - 1'b1;
                    default: r_cnt[v] <= r_cnt[v];
                endcase
                if (w_drop[v]) r_overflow[v] <= 1'b1;
            end
        end
    end

    // ---- output register ----
    // Register the winner; data_o holds its last value when nothing is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_o <= 1'b0;
            r_data_o  <= '0;
            r_rr_ptr  <= '0;
        end else begin
            r_valid_o <= w_grant_vld;
            if (w_grant_vld) begin
                r_data_o <= w_rd_data;
                r_rr_ptr <= f_vc_inc(w_grant_vc);
            end
        end
    end

    // ---- backward stages p0..p(STAGES-1) ----
    // On/off and allocatable both retime toward upstream and reset to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_onoff_p[i] <= '0;
                r_alloc_p[i] <= '0;
            end
        end else begin
            r_onoff_p[0] <= w_raw_on;
            r_alloc_p[0] <= is_allocatable_i;
            for (int i = 1; i < STAGES; i++) begin
                r_onoff_p[i] <= r_onoff_p[i-1];
                r_alloc_p[i] <= r_alloc_p[i-1];
            end
        end
    end

    assign is_on_off_o      = r_onoff_p[STAGES-1];
    assign is_allocatable_o = r_alloc_p[STAGES-1];
    assign is_valid_o       = r_valid_o;
    assign data_o           = r_data_o;
    assign overflow_o       = r_overflow;

`ifdef LINK_STATS_EN
    logic [15:0] r_flit_cnt [VC_NUM];

    // Count flits delivered per VC; wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < VC_NUM; v++) r_flit_cnt[v] <= '0;
        end else begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (w_pop[v]) r_flit_cnt[v] <= r_flit_cnt[v] + 16'd1;
            end
        end
    end

    // Pack the per-VC counters onto the flat port.
    always_comb begin
        flit_count_o = '0;
        for (int v = 0; v < VC_NUM; v++) flit_count_o[v*16 +: 16] = r_flit_cnt[v];
    end
`else
    assign flit_count_o = '0;
`endif

    // A tail flit must name an existing VC; otherwise it is silently discarded.
    assert property (@(posedge clk) disable iff (rst)
        w_tail_vld |-> (int'(w_tail_vc) < VC_NUM));

endmodule

// File: tb/tb_router_link_pipelined.sv
// Scoreboard bench for router_link_pipelined with STAGES=2, SKID_EXTRA=2, VC_NUM=2
// (RTT=5, DEPTH=7, latency 4 cycles).
module tb_router_link_pipelined;
    import noc_pkg::*;

    localparam int STAGES     = 2;
    localparam int SKID_EXTRA = 2;
    localparam int DATA_W     = $bits(flit_t);

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [DATA_W-1:0]     data_i;
    logic                  is_valid_i;
    logic [VC_NUM-1:0]     is_on_off_o;
    logic [VC_NUM-1:0]     is_allocatable_o;
    logic [DATA_W-1:0]     data_o;
    logic                  is_valid_o;
    logic [VC_NUM-1:0]     is_on_off_i;
    logic [VC_NUM-1:0]     is_allocatable_i;
    logic [VC_NUM-1:0]     overflow_o;
    logic [VC_NUM*16-1:0]  flit_count_o;

    router_link_pipelined #(.STAGES(STAGES), .SKID_EXTRA(SKID_EXTRA)) dut (
        .clk              (clk),
        .rst              (rst),
        .data_i           (data_i),
        .is_valid_i       (is_valid_i),
        .is_on_off_o      (is_on_off_o),
        .is_allocatable_o (is_allocatable_o),
        .data_o           (data_o),
        .is_valid_o       (is_valid_o),
        .is_on_off_i      (is_on_off_i),
        .is_allocatable_i (is_allocatable_i),
        .overflow_o       (overflow_o),
        .flit_count_o     (flit_count_o)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_pass   = 0;
    flit_t exp_q[$];
    int    deliv[VC_NUM];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int vc, input logic [31:0] pl, input bit expect_out);
        flit_t f;
        f.vc_id   = VC_SIZE'(vc);
        f.payload = pl;
        data_i     = f;
        is_valid_i = 1'b1;
        if (expect_out) exp_q.push_back(f);
        tick();
        is_valid_i = 1'b0;
    endtask

    // Monitor: every delivered flit must match the head of the expected queue.
    always @(negedge clk) begin : monitor
        flit_t got;
        flit_t e;
        if (rst) begin
            for (int v = 0; v < VC_NUM; v++) deliv[v] = 0;
        end else if (is_valid_o) begin
            got = flit_t'(data_o);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_flit: got %0h expected none", data_o);
            end else begin
                e = exp_q.pop_front();
                check("sb_flit", data_o, e);
            end
            deliv[int'(got.vc_id)]++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        flit_t f;
        bit    on_prev;
        int    sent, total, run, maxrun;
        logic [15:0] exp_cnt;
        logic [VC_NUM-1:0] apat [12];

        apat = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b11, 2'b01,
                 2'b00, 2'b10, 2'b10, 2'b01, 2'b11, 2'b00};
        data_i           = '0;
        is_valid_i       = 1'b0;
        is_on_off_i      = 2'b11;
        is_allocatable_i = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", is_valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_onoff", is_on_off_o, 0);
        check("rst_alloc", is_allocatable_o, 0);
        check("rst_ovf", overflow_o, 0);
        check("rst_cnt", flit_count_o, 0);
        rst = 1'b0;
        repeat (5) tick();
        check("onoff_after_rst", is_on_off_o, 2'b11);

        // Test 1: single flit latency and data
        f.vc_id = 0; f.payload = 32'hA5A5_0001;
        data_i = f; is_valid_i = 1'b1; exp_q.push_back(f);
        tick();
        is_valid_i = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("t1_not_early", is_valid_o, 0);
        tick();
        check("t1_valid_lat", is_valid_o, 1);
        check("t1_data", data_o, f);
        repeat (4) tick();
        check("t1_onoff", is_on_off_o, 2'b11);

        // Test 2: upstream obeys on/off (registered) with downstream off
        is_on_off_i = 2'b00;
        on_prev = is_on_off_o[0];
        sent = 0;
        for (int j = 0; j < 16; j++) begin
            if (on_prev) begin
                f.vc_id = 0; f.payload = 32'h2000 + sent;
                data_i = f; is_valid_i = 1'b1; exp_q.push_back(f);
                sent++;
            end else begin
                is_valid_i = 1'b0;
            end
            on_prev = is_on_off_o[0];
            tick();
        end
        is_valid_i = 1'b0;
        check("t2_sent", sent, 7);
        check("t2_onoff", is_on_off_o, 2'b10);
        check("t2_ovf", overflow_o, 0);
        is_on_off_i = 2'b11;
        repeat (15) tick();
        check("t2_drain", exp_q.size(), 0);
        check("t2_onoff_back", is_on_off_o, 2'b11);

        // Test 3: both VCs full, alternating drain one per cycle
        @(posedge clk); #3 rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #3 rst = 1'b0;
        repeat (4) tick();
        is_on_off_i = 2'b00;
        for (int i = 0; i < 14; i++) drive(i % 2, 32'h3000 + i, 1'b1);
        repeat (4) tick();
        check("t3_ovf", overflow_o, 0);
        check("t3_onoff_full", is_on_off_o, 2'b00);
        is_on_off_i = 2'b11;
        total = 0; run = 0; maxrun = 0;
        for (int j = 0; j < 18; j++) begin
            @(negedge clk);
            if (is_valid_o) begin
                total++; run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
            tick();
        end
        check("t3_total", total, 14);
        check("t3_back_to_back", maxrun, 14);
        check("t3_drain", exp_q.size(), 0);

        // Test 4: forced overflow on vc1
        is_on_off_i = 2'b00;
        for (int i = 0; i < 7; i++) drive(1, 32'h4000 + i, 1'b1);
        repeat (4) tick();
        check("t4_no_ovf", overflow_o, 0);
        drive(1, 32'h4007, 1'b0);
        repeat (4) tick();
        check("t4_ovf", overflow_o, 2'b10);
        is_on_off_i = 2'b11;
        repeat (12) tick();
        check("t4_drain", exp_q.size(), 0);
        check("t4_ovf_sticky", overflow_o, 2'b10);

        // Test 5: reset mid-stream with 3 flits buffered
        is_on_off_i = 2'b00;
        for (int i = 0; i < 3; i++) drive(0, 32'h5000 + i, 1'b0);
        repeat (4) tick();
        is_on_off_i = 2'b11;
        tick();
        #1 rst = 1'b1;
        #1;
        check("t5_valid_async", is_valid_o, 0);
        check("t5_data_async", data_o, 0);
        check("t5_ovf_clr", overflow_o, 0);
        @(posedge clk); #3 rst = 1'b0;
        check("t5_onoff_low", is_on_off_o, 2'b00);
        repeat (STAGES + 1) @(posedge clk);
        #1;
        check("t5_onoff_back", is_on_off_o, 2'b11);
        repeat (10) tick();

        // Stats after a few deliveries
        for (int i = 0; i < 3; i++) drive(0, 32'h6000 + i, 1'b1);
        for (int i = 0; i < 2; i++) drive(1, 32'h6100 + i, 1'b1);
        repeat (8) tick();
        check("st_drain", exp_q.size(), 0);
        for (int v = 0; v < VC_NUM; v++) begin
`ifdef LINK_STATS_EN
            exp_cnt = 16'(deliv[v]);
`else
            exp_cnt = 16'h0;
`endif
            check("flit_count", flit_count_o[v*16 +: 16], exp_cnt);
        end

        // Allocatable delayed by STAGES cycles
        for (int j = 0; j < 12; j++) begin
            is_allocatable_i = apat[j];
            @(negedge clk);
            if (j >= STAGES) check("alloc_dly", is_allocatable_o, apat[j-STAGES]);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
